// File: rtl/stream_mux2_rr.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux2_rr
//  Description : Two-input packet-aware stream arbiter. Round-robin choice
//                between stream A and stream B at packet boundaries, grant
//                held until the winning packet's last beat is accepted, and
//                a single registered output stage carrying data, last flag
//                and the source select (0 = A, 1 = B).
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_mux2_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,

  // Stream A
  input  logic             i_a_valid,
  input  logic [WIDTH-1:0] i_a_data,
  input  logic             i_a_last,
  output logic             o_a_ready,

  // Stream B
  input  logic             i_b_valid,
  input  logic [WIDTH-1:0] i_b_data,
  input  logic             i_b_last,
  output logic             o_b_ready,

  // Registered output stream
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_last,
  output logic             o_out_sel,
  input  logic             i_out_ready
);

  // Arbitration state: IDLE means no packet is in flight, LOCK_x means
  // source x owns the output until its LAST beat has been accepted.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_ptr;        // 0: A favoured on a tie, 1: B favoured
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_out_sel;

  logic             w_slot_free;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_acc_a;
  logic             w_acc_b;

  // The output register can take a new beat when it is empty or being drained
  // this cycle; this is what gives one beat per cycle with no bubbles.
  assign w_slot_free = !r_out_valid || i_out_ready;

  // Grant selection: locked states ignore the other source entirely, IDLE
  // resolves a tie with the round-robin pointer.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_a_valid && (!i_b_valid || !r_ptr)) begin
          w_grant_a = 1'b1;
        end else if (i_b_valid) begin
          w_grant_b = 1'b1;
        end
      end
      ST_LOCK_A: w_grant_a = 1'b1;
      ST_LOCK_B: w_grant_b = 1'b1;
      default: begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
      end
    endcase
  end

  // Readies are forced low while reset is held so no source sees a phantom
  // handshake during the asynchronous reset window.
  assign o_a_ready = rst_n && w_grant_a && w_slot_free;
  assign o_b_ready = rst_n && w_grant_b && w_slot_free;

  assign w_acc_a = i_a_valid && o_a_ready;
  assign w_acc_b = i_b_valid && o_b_ready;

  // Single sequential process for the arbiter FSM, the round-robin pointer
  // and the registered output stage, so select and data can never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= 1'b0;
    end else begin
      if (w_acc_a) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_a_data;
        r_out_last  <= i_a_last;
        r_out_sel   <= 1'b0;
        if (i_a_last) begin
          r_state <= ST_IDLE;
          r_ptr   <= 1'b1;
        end else begin
          r_state <= ST_LOCK_A;
        end
      end else if (w_acc_b) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_b_data;
        r_out_last  <= i_b_last;
        r_out_sel   <= 1'b1;
        if (i_b_last) begin
          r_state <= ST_IDLE;
          r_ptr   <= 1'b0;
        end else begin
          r_state <= ST_LOCK_B;
        end
      end else if (i_out_ready) begin
        // Beat drained with nothing to replace it; payload fields keep
        // their last loaded values.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux2_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_mux2_rr
//  Description : Self-checking bench for stream_mux2_rr. Sources are packet
//                queues; a cycle model built from the arbitration rules
//                predicts readies and the output register, and per-source
//                scoreboards check packet content and ordering.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux2_rr;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             i_a_valid, i_a_last, o_a_ready;
  logic [WIDTH-1:0] i_a_data;
  logic             i_b_valid, i_b_last, o_b_ready;
  logic [WIDTH-1:0] i_b_data;
  logic             o_out_valid, o_out_last, o_out_sel;
  logic [WIDTH-1:0] o_out_data;
  logic             i_out_ready;

  stream_mux2_rr #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_a_valid   (i_a_valid),
    .i_a_data    (i_a_data),
    .i_a_last    (i_a_last),
    .o_a_ready   (o_a_ready),
    .i_b_valid   (i_b_valid),
    .i_b_data    (i_b_data),
    .i_b_last    (i_b_last),
    .o_b_ready   (o_b_ready),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .o_out_last  (o_out_last),
    .o_out_sel   (o_out_sel),
    .i_out_ready (i_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  typedef struct packed {logic [7:0] d; logic l; logic s;} obeat_t;

  beat_t  qa[$], qb[$];      // beats still to be offered by each source
  beat_t  sba[$], sbb[$];    // beats expected at the output, per source
  obeat_t olog[$];           // beats observed leaving the output

  int total = 0;
  int bad   = 0;

  bit en_a, en_b;            // source willing to raise a new beat
  bit sh_a, sh_b;            // source currently presenting its head beat

  // Reference view: who owns the channel (0 none, 1 A, 2 B), whose turn a
  // tie is, and what the output register should be holding.
  int         owner;
  bit         turn_b;
  bit         m_v, m_l, m_s;
  logic [7:0] m_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    owner = 0; turn_b = 0;
    m_v = 0; m_l = 0; m_s = 0; m_d = 8'h00;
  endtask

  task automatic add_beat(input bit src, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    if (src) begin qb.push_back(b); sbb.push_back(b); end
    else     begin qa.push_back(b); sba.push_back(b); end
  endtask

  // Raise a source's head beat when allowed; once raised it is held.
  task automatic drive();
    if (!sh_a && qa.size() > 0 && en_a) sh_a = 1;
    if (!sh_b && qb.size() > 0 && en_b) sh_b = 1;
    i_a_valid = sh_a;
    if (sh_a) begin i_a_data = qa[0].d; i_a_last = qa[0].l; end
    i_b_valid = sh_b;
    if (sh_b) begin i_b_data = qb[0].d; i_b_last = qb[0].l; end
  endtask

  // One clock: check at the falling edge, advance model after the rising edge.
  task automatic cycle();
    bit slot, ga, gb, ra, rb, aa, ab, dut_aa, dut_ab;
    int         n_owner;
    bit         n_turn, n_v, n_l, n_s;
    logic [7:0] n_d;
    beat_t      e;
    @(negedge clk);
    slot = !m_v || i_out_ready;
    ga = (owner == 1) || (owner == 0 && i_a_valid && (!i_b_valid || !turn_b));
    gb = (owner == 2) || (owner == 0 && i_b_valid && !ga);
    ra = ga && slot;
    rb = gb && slot;
    check("a_ready",   32'(o_a_ready),   32'(ra));
    check("b_ready",   32'(o_b_ready),   32'(rb));
    check("out_valid", 32'(o_out_valid), 32'(m_v));
    check("out_data",  32'(o_out_data),  32'(m_d));
    check("out_last",  32'(o_out_last),  32'(m_l));
    check("out_sel",   32'(o_out_sel),   32'(m_s));
    if (o_out_valid && i_out_ready) begin
      olog.push_back({o_out_data, o_out_last, o_out_sel});
      if (o_out_sel) begin
        check("sb_b_has_beat", 32'(sbb.size() > 0), 32'd1);
        if (sbb.size() > 0) begin
          e = sbb.pop_front();
          check("sb_b_data", 32'(o_out_data), 32'(e.d));
          check("sb_b_last", 32'(o_out_last), 32'(e.l));
        end
      end else begin
        check("sb_a_has_beat", 32'(sba.size() > 0), 32'd1);
        if (sba.size() > 0) begin
          e = sba.pop_front();
          check("sb_a_data", 32'(o_out_data), 32'(e.d));
          check("sb_a_last", 32'(o_out_last), 32'(e.l));
        end
      end
    end
    aa = i_a_valid && ra;
    ab = i_b_valid && rb;
    n_owner = owner; n_turn = turn_b;
    n_v = m_v; n_d = m_d; n_l = m_l; n_s = m_s;
    if (aa) begin
      n_v = 1; n_d = i_a_data; n_l = i_a_last; n_s = 0;
      n_owner = i_a_last ? 0 : 1;
      if (i_a_last) n_turn = 1;
    end else if (ab) begin
      n_v = 1; n_d = i_b_data; n_l = i_b_last; n_s = 1;
      n_owner = i_b_last ? 0 : 2;
      if (i_b_last) n_turn = 0;
    end else if (i_out_ready) begin
      n_v = 0;
    end
    dut_aa = i_a_valid && o_a_ready;
    dut_ab = i_b_valid && o_b_ready;
    @(posedge clk);
    #1;
    owner = n_owner; turn_b = n_turn;
    m_v = n_v; m_d = n_d; m_l = n_l; m_s = n_s;
    if (dut_aa && qa.size() > 0) begin void'(qa.pop_front()); sh_a = 0; end
    if (dut_ab && qb.size() > 0) begin void'(qb.pop_front()); sh_b = 0; end
    drive();
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock.
  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_out_data",  32'(o_out_data),  32'd0);
    check("rst_out_last",  32'(o_out_last),  32'd0);
    check("rst_out_sel",   32'(o_out_sel),   32'd0);
    check("rst_a_ready",   32'(o_a_ready),   32'd0);
    check("rst_b_ready",   32'(o_b_ready),   32'd0);
    reset_model();
    qa.delete(); qb.delete(); sba.delete(); sbb.delete(); olog.delete();
    sh_a = 0; sh_b = 0; en_a = 0; en_b = 0;
    i_a_valid = 0; i_b_valid = 0; i_a_last = 0; i_b_last = 0;
    i_a_data = '0; i_b_data = '0;
    i_out_ready = 1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    drive();
  endtask

  initial begin
    bit done;
    // Power-on reset with A already valid: readies must stay low.
    rst_n = 0; i_out_ready = 1;
    i_a_valid = 1; i_a_data = 8'h77; i_a_last = 1;
    i_b_valid = 1; i_b_data = 8'h66; i_b_last = 1;
    en_a = 0; en_b = 0; sh_a = 0; sh_b = 0;
    reset_model();
    @(posedge clk); @(negedge clk);
    check("por_a_ready",   32'(o_a_ready),   32'd0);
    check("por_b_ready",   32'(o_b_ready),   32'd0);
    check("por_out_valid", 32'(o_out_valid), 32'd0);
    @(posedge clk); #1;

    // Mid-simulation reset and idle period with no valids.
    do_reset();
    repeat (3) cycle();

    // Single source, one 3-beat packet.
    add_beat(0, 8'h11, 0); add_beat(0, 8'h22, 0); add_beat(0, 8'h33, 1);
    en_a = 1; drive();
    repeat (6) cycle();
    check("pkt_count", 32'(olog.size()), 32'd3);
    if (olog.size() == 3) begin
      check("pkt_d0", 32'(olog[0]), 32'({8'h11, 1'b0, 1'b0}));
      check("pkt_d1", 32'(olog[1]), 32'({8'h22, 1'b0, 1'b0}));
      check("pkt_d2", 32'(olog[2]), 32'({8'h33, 1'b1, 1'b0}));
    end

    // Round-robin tie between continuous single-beat packets.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add_beat(0, 8'hAA, 1); add_beat(1, 8'hBB, 1);
    end
    en_a = 1; en_b = 1; drive();
    repeat (10) cycle();
    check("rr_count", 32'(olog.size()), 32'd8);
    for (int i = 0; i < 8 && i < olog.size(); i++) begin
      check("rr_data", 32'(olog[i].d), (i % 2 == 1) ? 32'h0BB : 32'h0AA);
      check("rr_sel",  32'(olog[i].s), 32'(i % 2));
    end

    // Packet lock: B holds the grant through a two-cycle source gap.
    do_reset();
    add_beat(1, 8'hC1, 0); add_beat(1, 8'hC2, 0);
    add_beat(1, 8'hC3, 0); add_beat(1, 8'hC4, 1);
    en_b = 1; drive();
    cycle();
    add_beat(0, 8'hA5, 1); en_a = 1; drive();
    en_b = 0;
    cycle();
    cycle(); cycle();
    en_b = 1; drive();
    repeat (8) cycle();
    check("lock_count", 32'(olog.size()), 32'd5);
    if (olog.size() == 5) begin
      check("lock_b3",  32'(olog[3]), 32'({8'hC4, 1'b1, 1'b1}));
      check("lock_a0",  32'(olog[4]), 32'({8'hA5, 1'b1, 1'b0}));
    end

    // Backpressure: output held at 0x5C for three stalled cycles.
    do_reset();
    add_beat(0, 8'h5C, 1); add_beat(0, 8'h5D, 1);
    en_a = 1; drive();
    cycle();
    i_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold_data",  32'(o_out_data),  32'h05C);
      check("bp_hold_valid", 32'(o_out_valid), 32'd1);
    end
    i_out_ready = 1;
    cycle();
    check("bp_next_data", 32'(o_out_data), 32'h05D);

    // Reset in the middle of an A packet while B waits.
    do_reset();
    add_beat(0, 8'h61, 0); add_beat(0, 8'h62, 0);
    add_beat(0, 8'h63, 0); add_beat(0, 8'h64, 1);
    add_beat(1, 8'hBA, 1);
    en_a = 1; en_b = 1; drive();
    cycle(); cycle();
    check("mid_valid_before", 32'(o_out_valid), 32'd1);
    do_reset();
    add_beat(0, 8'h71, 1); add_beat(1, 8'h81, 1);
    en_a = 1; en_b = 1; drive();
    repeat (4) cycle();
    check("mid_count", 32'(olog.size()), 32'd2);
    if (olog.size() == 2) begin
      check("mid_first",  32'(olog[0]), 32'({8'h71, 1'b1, 1'b0}));
      check("mid_second", 32'(olog[1]), 32'({8'h81, 1'b1, 1'b1}));
    end

    // Randomized traffic: packet lengths, source gaps and backpressure.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (qa.size() < 3 && $urandom_range(0, 2) == 0) begin
        int n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) add_beat(0, 8'($urandom), k == n - 1);
      end
      if (qb.size() < 3 && $urandom_range(0, 2) == 0) begin
        int n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) add_beat(1, 8'($urandom), k == n - 1);
      end
      en_a = ($urandom_range(0, 3) != 0);
      en_b = ($urandom_range(0, 3) != 0);
      i_out_ready = ($urandom_range(0, 3) != 0);
      drive();
      cycle();
    end

    // Drain with a bounded cycle budget.
    en_a = 1; en_b = 1; i_out_ready = 1; drive();
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      cycle();
      done = (qa.size() == 0 && qb.size() == 0 && !o_out_valid);
    end
    check("drain_done",  32'(done),        32'd1);
    check("drain_sb_a",  32'(sba.size()),  32'd0);
    check("drain_sb_b",  32'(sbb.size()),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_mux2_rr.md
Name: stream_mux2_rr

Overview:
- Two-input, packet-aware stream arbiter that feeds the 2:1 data-select stage.
- Selects between stream A and stream B using round-robin arbitration and holds the grant until the winning packet's last beat is accepted.
- Provides valid/ready handshaking and a single registered output stage.
- Exports the registered select (OUT_SEL) so downstream MUX2_1 instances and sideband logic stay aligned with the data.

Parameters:
- WIDTH, 8, data width of each input stream and of the output.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- A_VALID  input  1  stream A beat valid.
- A_DATA  input  WIDTH  stream A beat data.
- A_LAST  input  1  stream A final beat of packet.
- A_READY  output  1  stream A beat accepted this cycle when A_VALID=1.
- B_VALID  input  1  stream B beat valid.
- B_DATA  input  WIDTH  stream B beat data.
- B_LAST  input  1  stream B final beat of packet.
- B_READY  output  1  stream B beat accepted this cycle when B_VALID=1.
- OUT_VALID  output  1  output beat valid (registered).
- OUT_DATA  output  WIDTH  output beat data (registered).
- OUT_LAST  output  1  output final beat (registered).
- OUT_SEL  output  1  source of the current output beat: 0=A, 1=B (registered).
- OUT_READY  input  1  downstream accepts the output beat.

Behaviour:
- Reset (RST_N=0, asynchronous): OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, OUT_SEL=0, state=IDLE, priority pointer PTR=0 (A favoured). A_READY and B_READY are 0 while reset is asserted.
- Reset mid-packet: the packet in progress is abandoned and OUT_VALID drops immediately. After release, arbitration restarts from IDLE with PTR=0.
- SLOT_FREE = !OUT_VALID || OUT_READY. The output register loads only on an accepted input beat. When OUT_READY=1 and no input beat is accepted, OUT_VALID clears.
- States:
  - IDLE: no grant held.
  - LOCK_A: mid-packet from A.
  - LOCK_B: mid-packet from B.
- Grant, combinational:
  - IDLE, only A_VALID: grant A.
  - IDLE, only B_VALID: grant B.
  - IDLE, both valid: grant A if PTR=0, otherwise grant B.
  - LOCK_A: grant A only, regardless of B_VALID.
  - LOCK_B: grant B only, regardless of A_VALID.
- Ready: A_READY = grantA && SLOT_FREE. B_READY = grantB && SLOT_FREE. A_READY and B_READY are never both 1.
- Accept: a beat is accepted when x_VALID && x_READY. On the next rising edge OUT_DATA, OUT_LAST, OUT_VALID=1 and OUT_SEL=x are loaded. Latency from accept to output visibility is exactly 1 cycle.
- Throughput: 1 beat/cycle with OUT_READY held high, including across packet boundaries and source switches. There are no bubbles on arbitration.
- Transitions on an accepted beat:
  - LAST=0: go to LOCK_x.
  - LAST=1: go to IDLE and set PTR to the other source.
  - No accept: hold state and PTR.
- Single-beat packet: accepted in IDLE with LAST=1. The state stays in IDLE and PTR flips.
- Backpressure: while OUT_VALID=1 and OUT_READY=0, all OUT_* outputs are held stable and both READY outputs are 0.
- Lock persistence: in LOCK_x with x_VALID=0 (source gap), the grant is held and the other source waits indefinitely.
- Protocol rule on sources: once raised, x_VALID, x_DATA and x_LAST are held stable until accepted. The block does not check this.
- Idle output: OUT_DATA, OUT_LAST and OUT_SEL retain their last loaded values when OUT_VALID=0.

Test Plan:
- Reset and idle:
  - Stimulus: assert RST_N=0 mid-simulation, then release RST_N, with no valids asserted.
  - Response: all OUT_* outputs are 0 immediately on reset assertion; after release, A_READY=B_READY=0 and OUT_VALID stays 0.
- Single source, back-to-back packets:
  - Stimulus: A sends 3-beat packet 0x11, 0x22, 0x33 (LAST on 0x33); OUT_READY=1.
  - Response: OUT_DATA shows 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after its accept; OUT_SEL=0; OUT_LAST=1 only with 0x33.
- Round-robin tie:
  - Stimulus: A and B both offer single-beat packets continuously (A=0xAA, B=0xBB); OUT_READY=1.
  - Response: OUT_DATA alternates 0xAA, 0xBB, 0xAA, 0xBB, starting with A; OUT_SEL toggles 0, 1, 0, 1.
- Packet lock:
  - Stimulus: B starts a 4-beat packet; A_VALID rises after B's first beat; B_VALID deasserts for 2 cycles mid-packet.
  - Response: A_READY stays 0 until B's LAST beat is accepted; A's first beat appears at the output the cycle after B's LAST beat is output.
- Backpressure:
  - Stimulus: OUT_READY=0 for 3 cycles while OUT_VALID=1 with OUT_DATA=0x5C.
  - Response: OUT_DATA stays 0x5C and A_READY=B_READY=0 for all 3 cycles; the next beat is accepted in the cycle OUT_READY returns to 1.
- Reset mid-packet:
  - Stimulus: pull RST_N low after beat 2 of a 4-beat packet from A, then release it; B is valid.
  - Response: OUT_VALID=0 immediately on reset assertion; after release, a tie grants A (PTR=0).
